mips_mc: RTL

MIPS_MC -- requirements
Module: mips_mc

---
 rtl/mips_mc.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mips_mc.sv
// mips_mc: multi-cycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB) sharing one memory port.
// Define MIPS_MC_MULTDIV_EN to add HI/LO with mult, multu, mfhi, mflo, mthi, mtlo.
module mips_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} stateT;
    stateT       state, nextState;
    logic [31:0] pc, ir, regA, regB, mdr, aluOut, aluRes, hiVal, loVal, sImm, zImm;
    logic [31:0] gpr [32];
    logic [3:0]  cnt;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, dest;
    logic [15:0] imm;
    logic isR, isAddu, isSubu, isSll, isJr, isOri, isLui, isLw, isSw, isBeq, isJ, isJal;
    logic isMfhi, isMflo, isMthi, isMtlo, isMult, isMultu, isMul, isJump, valid, lastCycle, wbJal;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign shamt   = ir[10:6];
    assign funct   = ir[5:0];
    assign imm     = ir[15:0];
    assign sImm    = {{16{imm[15]}}, imm};
    assign zImm    = {16'd0, imm};
    assign isR     = op == 6'h00;
    assign isAddu  = isR && funct == 6'h21;
    assign isSubu  = isR && funct == 6'h23;
    assign isSll   = isR && funct == 6'h00;
    assign isJr    = isR && funct == 6'h08;
    assign isOri   = op == 6'h0D;
    assign isLui   = op == 6'h0F;
    assign isLw    = op == 6'h23;
    assign isSw    = op == 6'h2B;
    assign isBeq   = op == 6'h04;
    assign isJ     = op == 6'h02;
    assign isJal   = op == 6'h03;

`ifdef MIPS_MC_MULTDIV_EN
    logic [31:0] hi, lo;
    logic [63:0] prod;
    assign isMfhi  = isR && funct == 6'h10;
    assign isMthi  = isR && funct == 6'h11;
    assign isMflo  = isR && funct == 6'h12;
    assign isMtlo  = isR && funct == 6'h13;
    assign isMult  = isR && funct == 6'h18;
    assign isMultu = isR && funct == 6'h19;
    assign hiVal   = hi;
    assign loVal   = lo;
    // Sign- or zero-extend to 64 bits; the low 64 product bits are then correct for both.
    assign prod = {isMult ? {32{regA[31]}} : 32'd0, regA} * {isMult ? {32{regB[31]}} : 32'd0, regB};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == EXEC) begin
            if (isMul && lastCycle) {hi, lo} <= prod;
            if (isMthi) hi <= regA;
            if (isMtlo) lo <= regA;
        end
    end
`else
    assign isMfhi  = 1'b0;
    assign isMthi  = 1'b0;
    assign isMflo  = 1'b0;
    assign isMtlo  = 1'b0;
    assign isMult  = 1'b0;
    assign isMultu = 1'b0;
    assign hiVal   = '0;
    assign loVal   = '0;
`endif

    assign isMul     = isMult || isMultu;
    assign isJump    = isJ || isJal || isJr;
    assign valid     = isAddu || isSubu || isSll || isOri || isLui || isLw || isSw || isBeq || isJump
                     || isMfhi || isMflo || isMthi || isMtlo || isMul;
    assign dest      = isR ? rd : rt;
    assign lastCycle = cnt == 4'(MULT_LAT - 1);

    assign aluRes = isAddu ? regA + regB :
                    isSubu ? regA - regB :
                    isSll ? regB << shamt :
                    isOri ? regA | zImm :
                    isLui ? {imm, 16'd0} :
                    (isLw || isSw) ? regA + sImm :
                    isMfhi ? hiVal :
                    isMflo ? loVal : '0;

    always_comb begin
        nextState = state;
        case (state)
            FETCH:   nextState = mem_ack ? DECODE : FETCH;
            DECODE:  nextState = (valid && !isJump) ? EXEC : FETCH;
            EXEC:    nextState = (isBeq || isMthi || isMtlo) ? FETCH :
                                 isMul ? (lastCycle ? FETCH : EXEC) :
                                 (isLw || isSw) ? MEM : WB;
            MEM:     nextState = mem_ack ? (isLw ? WB : FETCH) : MEM;
            WB:      nextState = FETCH;
            default: nextState = FETCH;
        endcase
    end

    // Bus and writeback outputs are gated by reset so they drop the moment reset asserts.
    assign mem_req   = reset && (state == FETCH || state == MEM);
    assign mem_we    = reset && state == MEM && isSw;
    assign mem_addr  = !reset ? '0 : state == FETCH ? pc & ~32'd3 : state == MEM ? aluOut & ~32'd3 : '0;
    assign mem_wdata = mem_we ? regB : '0;
    assign wbJal     = state == DECODE && isJal;
    assign wb_we     = reset && (wbJal || (state == WB && dest != 5'd0));
    assign wb_reg    = !wb_we ? 5'd0 : wbJal ? 5'd31 : dest;
    assign wb_data   = !wb_we ? '0 : wbJal ? pc : isLw ? mdr : aluOut;
    assign wb_pc     = wb_we ? pc - 32'd4 : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            regA   <= '0;
            regB   <= '0;
            mdr    <= '0;
            aluOut <= '0;
            cnt    <= '0;
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else begin
            state <= nextState;
            if (state == FETCH && mem_ack) begin
                ir <= mem_rdata;
                pc <= pc + 32'd4;
            end
            if (state == DECODE) begin
                regA <= gpr[rs];
                regB <= gpr[rt];
                pc   <= isJr ? gpr[rs] : (isJ || isJal) ? {pc[31:28], ir[25:0], 2'b00} : pc;
            end
            if (state == EXEC) begin
                aluOut <= aluRes;
                cnt    <= (isMul && nextState == EXEC) ? cnt + 4'd1 : 4'd0;
                if (isBeq && regA == regB) pc <= pc + (sImm << 2);
            end
            if (state == MEM && mem_ack) mdr <= mem_rdata;
            if (wb_we) gpr[wb_reg] <= wb_data;
        end
    end
endmodule
